// File: rtl/step_pkg.sv
// step_pkg: shared encodings for the step arbiter.
// Progress states, command opcodes and the STEP successor.
package step_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_e;

  localparam logic OP_STEP  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  // Successor of a STEP; S4 saturates, illegal codes fall to S0.
  function automatic logic [2:0] step_next(
    input logic [2:0] s
  );
    logic [2:0] n;
    case (s)
      S0:      n = S1;
      S1:      n = S2;
      S2:      n = S3;
      S3:      n = S4;
      S4:      n = S4;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant decision.
// Masked requesters are ineligible; pointer moves past each winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic       ptr_q;
  logic       ptr_d;
  logic [1:0] elig;

  // Pick a winner; on a tie the pointer decides, then flips.
  always_comb begin
    elig  = req & ~mask;
    gnt   = 2'b00;
    ptr_d = ptr_q;
    unique case (1'b1)
      (elig == 2'b11): gnt = ptr_q ? 2'b10 : 2'b01;
      (elig == 2'b01): gnt = 2'b01;
      (elig == 2'b10): gnt = 2'b10;
      default:         gnt = 2'b00;
    endcase
    if (|gnt) ptr_d = gnt[0];
  end

  // Pointer register; favours requester 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/step_arbiter.sv
// step_arbiter: two requesters share a S0..S4 progress counter.
// S4 can auto-release after a hold countdown.
module step_arbiter
  import step_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] op,
  output logic [1:0] gnt,
  output logic [2:0] state,
  output logic       on,
  output logic       hold
);

  localparam logic HOLD_EN = (HOLD_CYCLES > 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    CNT_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic [1:0]       gnt_q;
  logic [1:0]       gnt_d;
  logic [1:0]       mask;
  logic             legal;
  logic             in_s4;
  logic             cmd_v;
  logic             cmd_op;

  assign legal = (state_q <= S4);
  assign in_s4 = (state_q == S4);

  // A requester just granted is ignored this cycle; an illegal
  // state blocks everyone so recovery consumes no command.
  assign mask = gnt_q | {2{~legal}};

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mask (mask),
    .gnt  (gnt_d)
  );

  // Next state: illegal recovery, then expiry, then the command.
  always_comb begin
    cmd_v   = |gnt_d;
    cmd_op  = gnt_d[1] ? op[1] : op[0];
    state_d = state_q;
    if (!legal) begin
      state_d = S0;
    end else if (in_s4 && HOLD_EN && timer_q == '0) begin
      state_d = S0;
    end else if (cmd_v) begin
      state_d = (cmd_op == OP_STEP) ? step_next(state_q) : S0;
    end
  end

  // Timer loads on S4 entry, counts down while staying in S4.
  always_comb begin
    timer_d = '0;
    if (HOLD_EN && state_d == S4) begin
      timer_d = in_s4 ? timer_q - CNT_W'(1) : HOLD_LOAD;
    end
  end

  // State, timer and acknowledge registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
      timer_q <= '0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign state = state_q;
  assign on    = in_s4;
  assign hold  = in_s4 & HOLD_EN;

endmodule

// File: tb/tb_step_arbiter.sv
// tb_step_arbiter: vector table, corner sequences and a random
// run against a behavioural model, for HOLD_CYCLES 8 and 0.
module tb_step_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op  = 2'b00;
  logic [1:0] gnt, gnt0;
  logic [2:0] state, state0;
  logic       on, on0, hold, hold0;

  int checks = 0;
  int errors = 0;

  step_arbiter #(.HOLD_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op),
    .gnt(gnt), .state(state), .on(on), .hold(hold)
  );

  step_arbiter #(.HOLD_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .req(req), .op(op),
    .gnt(gnt0), .state(state0), .on(on0), .hold(hold0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] op;
    logic [1:0] gnt;
    logic [2:0] st;
    logic       on;
    logic       hold;
  } vec_t;

  typedef struct {
    int         lvl;
    int         left;
    int         ptr;
    logic [1:0] g;
  } model_t;

  localparam model_t MR = '{lvl: 0, left: 0, ptr: 0, g: 2'b00};

  vec_t   tv[$];
  model_t m8, m0;

  function automatic logic [31:0] o8();
    return 32'({gnt, state, on, hold});
  endfunction

  function automatic logic [31:0] o0();
    return 32'({gnt0, state0, on0, hold0});
  endfunction

  // Level 0..4, left = S4 cycles still to spend, g = last grant.
  function automatic model_t mstep(
    input model_t m, input logic [1:0] r,
    input logic [1:0] o, input int h
  );
    model_t     n;
    logic [1:0] e;
    logic [1:0] g;
    int         nl;
    n = m;
    e = r & ~m.g;
    if (e == 2'b11) g = (m.ptr == 0) ? 2'b01 : 2'b10;
    else            g = e;
    if (g != 2'b00) n.ptr = g[0] ? 1 : 0;
    nl = m.lvl;
    if (m.lvl == 4 && h > 0 && m.left == 1) nl = 0;
    else if (g != 2'b00)
      nl = o[g[1]] ? 0 : ((m.lvl < 4) ? m.lvl + 1 : 4);
    if (nl == 4) n.left = (m.lvl == 4) ? m.left - 1 : h;
    else         n.left = 0;
    n.lvl = nl;
    n.g   = g;
    return n;
  endfunction

  function automatic logic [31:0] mexp(input model_t m, input int h);
    logic [2:0] s;
    s = 3'(m.lvl);
    return 32'({m.g, s, (m.lvl == 4), (m.lvl == 4 && h > 0)});
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] o);
    @(negedge clk);
    req = r;
    op  = o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    op  = 2'b00;
    @(posedge clk);
    #1;
    chk("reset8", o8(), 32'd0);
    chk("reset0", o0(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(
    input logic rs, input logic [1:0] r, input logic [1:0] o,
    input logic [1:0] g, input logic [2:0] s,
    input logic n, input logic h
  );
    tv.push_back('{rs, r, o, g, s, n, h});
  endtask

  task automatic to_s4_pair();
    add(1, 2'b11, 2'b00, 2'b01, 3'd1, 0, 0);
    add(0, 2'b11, 2'b00, 2'b10, 3'd2, 0, 0);
    add(0, 2'b11, 2'b00, 2'b01, 3'd3, 0, 0);
    add(0, 2'b11, 2'b00, 2'b10, 3'd4, 1, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r, o;
    int         cnt;

    // single requester held: grant every 2nd cycle, then expiry
    add(1, 2'b01, 2'b00, 2'b01, 3'd1, 0, 0);
    add(0, 2'b01, 2'b00, 2'b00, 3'd1, 0, 0);
    add(0, 2'b01, 2'b00, 2'b01, 3'd2, 0, 0);
    add(0, 2'b01, 2'b00, 2'b00, 3'd2, 0, 0);
    add(0, 2'b01, 2'b00, 2'b01, 3'd3, 0, 0);
    add(0, 2'b01, 2'b00, 2'b00, 3'd3, 0, 0);
    add(0, 2'b01, 2'b00, 2'b01, 3'd4, 1, 1);
    add(0, 2'b01, 2'b00, 2'b00, 3'd4, 1, 1);
    add(0, 2'b01, 2'b00, 2'b01, 3'd4, 1, 1);
    add(0, 2'b01, 2'b00, 2'b00, 3'd4, 1, 1);
    for (int k = 0; k < 4; k++)
      add(0, 2'b00, 2'b00, 2'b00, 3'd4, 1, 1);
    add(0, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0);
    // both requesting: alternate grants, S4 after 4
    to_s4_pair();
    add(0, 2'b11, 2'b00, 2'b01, 3'd4, 1, 1);
    add(0, 2'b11, 2'b00, 2'b10, 3'd4, 1, 1);
    // CLEAR from S2
    add(1, 2'b01, 2'b00, 2'b01, 3'd1, 0, 0);
    add(0, 2'b00, 2'b00, 2'b00, 3'd1, 0, 0);
    add(0, 2'b01, 2'b00, 2'b01, 3'd2, 0, 0);
    add(0, 2'b10, 2'b10, 2'b10, 3'd0, 0, 0);
    add(0, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0);
    // STEP on the expiry cycle
    to_s4_pair();
    for (int k = 0; k < 7; k++)
      add(0, 2'b00, 2'b00, 2'b00, 3'd4, 1, 1);
    add(0, 2'b01, 2'b00, 2'b01, 3'd0, 0, 0);
    add(0, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0);
    // CLEAR in S4, first cycle masked by the previous grant
    to_s4_pair();
    add(0, 2'b10, 2'b10, 2'b00, 3'd4, 1, 1);
    add(0, 2'b10, 2'b10, 2'b10, 3'd0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      drive(tv[i].req, tv[i].op);
      chk($sformatf("vec%0d", i), o8(),
          32'({tv[i].gnt, tv[i].st, tv[i].on, tv[i].hold}));
    end

    // hold length with no requests
    do_reset();
    for (int k = 0; k < 4; k++) drive(2'b11, 2'b00);
    cnt = hold ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      drive(2'b00, 2'b00);
      if (hold) cnt++;
      if (state == 3'd0) break;
    end
    chk("hold_len", 32'(cnt), 32'd8);
    chk("hold_end", o8(), 32'd0);

    // reset mid-hold, then re-arbitrate from pointer 0
    do_reset();
    for (int k = 0; k < 5; k++) drive(2'b11, 2'b00);
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    @(negedge clk);
    req = 2'b11;
    rst = 1'b1;
    #1;
    chk("rst_async", o8(), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held", o8(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rearb", o8(), 32'({2'b01, 3'd1, 1'b0, 1'b0}));

    // HOLD_CYCLES=0: S4 sticks, hold never rises
    do_reset();
    for (int k = 0; k < 4; k++) drive(2'b11, 2'b00);
    for (int k = 0; k < 20; k++) begin
      drive(2'b00, 2'b00);
      chk("h0_s4", o0(), 32'({2'b00, 3'd4, 1'b1, 1'b0}));
    end
    // illegal code recovers to S0 without granting
    @(negedge clk);
    req = 2'b11;
    force dut0.state_q = 3'b110;
    #1;
    release dut0.state_q;
    #1;
    chk("illegal_dec", 32'({state0, on0, hold0}),
        32'({3'b110, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    chk("illegal_s0", o0(), 32'd0);
    drive(2'b11, 2'b00);
    chk("illegal_next", o0(), 32'({2'b01, 3'd1, 1'b0, 1'b0}));

    // random run against the model, both parameterisations
    do_reset();
    m8 = MR;
    m0 = MR;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        req = 2'b00;
        #2;
        chk("rand_rst8", o8(), 32'd0);
        chk("rand_rst0", o0(), 32'd0);
        rst = 1'b0;
        m8 = MR;
        m0 = MR;
      end else begin
        r = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
        o = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
        m8 = mstep(m8, r, o, 8);
        m0 = mstep(m0, r, o, 0);
        drive(r, o);
        chk("rand8", o8(), mexp(m8, 8));
        chk("rand0", o0(), mexp(m0, 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_arbiter.md
STEP_ARBITER -- requirements
Module: step_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8: cycles spent in S4 before auto-release to S0; 0 disables auto-release.
REQ-002 SHALL have parameter CNT_W, default 8: hold-timer width; HOLD_CYCLES SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  in  2  per-requester command request; req[i] is held until gnt[i].
REQ-006 SHALL have port op  in  2  per-requester opcode; op[i]=0 is STEP, op[i]=1 is CLEAR; valid while req[i]=1.
REQ-007 SHALL have port gnt  out  2  registered one-hot acknowledge, high for one cycle per executed command.
REQ-008 SHALL have port state  out  3  current progress state, S0=000 .. S4=100.
REQ-009 SHALL have port on  out  1  high iff state==S4.
REQ-010 SHALL have port hold  out  1  high while the hold timer is counting in S4.

Function
REQ-011 SHALL sample req on each rising clk edge; gnt and the resulting state update SHALL appear on the same edge, so latency is 1 cycle.
REQ-012 SHALL grant at most one requester per cycle, keeping gnt one-hot or zero.
REQ-013 SHALL grant the sole requester when exactly one req[i]=1 (req[i] masked as in REQ-015).
REQ-014 SHALL use a round-robin pointer when both requesters are eligible: grant the pointer's requester, then point to the other one; the pointer SHALL be 0 after reset and change only on a grant.
REQ-015 SHALL ignore req[i] in any cycle where gnt[i]=1, so a held request is not counted twice; a continuous req[i] therefore yields at most one grant every 2 cycles.
REQ-016 SHALL execute a granted STEP as S0->S1->S2->S3->S4, holding S4 when already in S4.
REQ-017 SHALL move to S0 on a granted CLEAR from any state.
REQ-018 SHALL load the hold timer with HOLD_CYCLES-1 and assert hold on entry to S4 when HOLD_CYCLES>0.
REQ-019 SHALL decrement the hold timer by 1 each cycle in S4; in the cycle the timer reads 0, the next state SHALL be S0 and hold SHALL drop.
REQ-020 SHALL not reload the timer on a STEP granted in S4.
REQ-021 SHALL go to S0 when timer expiry coincides with a granted STEP or CLEAR; gnt SHALL still pulse for that command.
REQ-022 SHALL force illegal state encodings 101-111 to S0 on the next edge with no gnt consumed, and SHALL deassert on and hold there.
REQ-023 SHALL leave outputs non-X when req bits are X only while gnt=0 is guaranteed; an implementation MAY assert on X req (verification-only check).

Reset
REQ-024 SHALL, while rst=1, hold state=S0, gnt=00, on=0, hold=0, timer=0 and RR pointer=0, regardless of clk.
REQ-025 SHALL abort any hold countdown or pending request when rst asserts mid-operation; after release, requests SHALL be re-arbitrated from pointer 0.

Structure
REQ-026 SHALL put the state encodings S0..S4 and the opcodes STEP/CLEAR in shared package step_pkg.
REQ-027 SHALL implement arbitration (REQ-012..015) in a sub-module rr_arb2: inputs clk, rst, req[1:0], mask[1:0]; output gnt[1:0].
REQ-028 SHALL use one registered state and one registered timer; on SHALL be decoded combinationally from state.

Verification
REQ-029 SHALL cover: req=01, op=00 held 10 cycles -> gnt0 pulses every 2nd cycle; state 0,1,2,3,4 then saturates; on=1 from S4 entry.
REQ-030 SHALL cover: req=11, op=00 continuous -> gnt alternates 01,10,01,...; state reaches S4 after 4 grants.
REQ-031 SHALL cover: HOLD_CYCLES=8, S4 reached and no req -> hold=1 for exactly 8 cycles, then state=S0 and on=0.
REQ-032 SHALL cover: in S2, req=10 with op[1]=1 -> gnt=10, state=S0 next edge.
REQ-033 SHALL cover: STEP granted on the timer-expiry cycle -> gnt pulses and state=S0; rst pulsed mid-hold -> immediate S0, gnt=00, pointer 0.
REQ-034 SHALL cover: HOLD_CYCLES=0 -> S4 held indefinitely, hold=0 throughout; forced state 110 -> S0 next edge.
